// File: rtl/count_seq_checker_pkg.sv
// ============================================================================
// Module  : count_seq_checker_pkg
// Brief   : Shared state encoding for the counter sequence checker.
// Revision: 1.0
// ============================================================================
`default_nettype none

package count_seq_checker_pkg;

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/count_seq_checker_sat.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at all-ones.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (inc && (r_q != {CNT_W{1'b1}})) begin
            r_q <= r_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/count_seq_checker.sv
// ============================================================================
// Module  : count_seq_checker
// Brief   : Checks that strobed counter samples increment by one (mod 2^WIDTH).
// Revision: 1.0
// ============================================================================
`default_nettype none

module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [WIDTH-1:0] din,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0] last_val
);

    localparam logic [3:0] c_lock_cnt = 4'(LOCK_CNT);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_ref;
    logic [3:0]       r_good;
    logic [WIDTH-1:0] r_last;
    logic             r_err_pulse;
    logic             r_wrap_pulse;

    logic [1:0]       w_state_nxt;
    logic [3:0]       w_good_nxt;
    logic             w_err;
    logic             w_wrap;
    logic             w_match;
    logic [3:0]       w_good_inc;

    assign w_match    = (din == (r_ref + {{(WIDTH-1){1'b0}}, 1'b1}));
    assign w_good_inc = r_good + 4'd1;

    // State register plus sample capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_SEARCH;
            r_ref        <= '0;
            r_good       <= '0;
            r_last       <= '0;
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_good       <= w_good_nxt;
            r_err_pulse  <= w_err;
            r_wrap_pulse <= w_wrap;
            if (valid) begin
                r_ref  <= din;
                r_last <= din;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_err       = 1'b0;
        w_wrap      = 1'b0;
        if (valid) begin
            case (r_state)
                ST_SEARCH: begin
                    w_state_nxt = ST_ACQUIRE;
                    w_good_nxt  = 4'd0;
                end
                ST_ACQUIRE: begin
                    if (w_match) begin
                        if (w_good_inc == c_lock_cnt) begin
                            w_state_nxt = ST_LOCKED;
                            w_good_nxt  = 4'd0;
                        end else begin
                            w_good_nxt  = w_good_inc;
                        end
                    end else begin
                        w_good_nxt = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (w_match) begin
                        w_wrap = (din == {WIDTH{1'b0}});
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_ACQUIRE;
                        w_good_nxt  = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = ST_SEARCH;
                    w_good_nxt  = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        locked     = (r_state == ST_LOCKED);
        err_pulse  = r_err_pulse;
        wrap_pulse = r_wrap_pulse;
        last_val   = r_last;
    end

    // Counters step on the same edge that raises the matching pulse
    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_err),
        .q     (err_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_wrap),
        .q     (wrap_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_count_seq_checker.sv
// ============================================================================
// Module  : tb_count_seq_checker
// Brief   : Directed bench with a behavioural reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_count_seq_checker;

    localparam int c_width = 4;
    localparam int c_lock  = 3;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [3:0] din;

    logic       a_locked, a_errp, a_wrapp;
    logic [7:0] a_errc, a_wrapc;
    logic [3:0] a_last;
    logic       b_locked, b_errp, b_wrapp;
    logic [1:0] b_errc, b_wrapc;
    logic [3:0] b_last;

    int pass_cnt  = 0;
    int total_cnt = 0;

    count_seq_checker dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .din(din),
        .locked(a_locked), .err_pulse(a_errp), .wrap_pulse(a_wrapp),
        .err_count(a_errc), .wrap_count(a_wrapc), .last_val(a_last)
    );

    count_seq_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .valid(valid), .din(din),
        .locked(b_locked), .err_pulse(b_errp), .wrap_pulse(b_wrapp),
        .err_count(b_errc), .wrap_count(b_wrapc), .last_val(b_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: tracks the run of consecutive +1 samples and totals
    logic m_have, m_locked, m_errp, m_wrapp;
    int   m_ref, m_last, m_streak, m_errs, m_wraps;

    function automatic int sat(input int v, input int bits);
        return (v > (1 << bits) - 1) ? (1 << bits) - 1 : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have <= 0; m_locked <= 0; m_errp <= 0; m_wrapp <= 0;
            m_ref <= 0; m_last <= 0; m_streak <= 0; m_errs <= 0; m_wraps <= 0;
        end else begin
            m_errp  <= 0;
            m_wrapp <= 0;
            if (valid) begin
                m_ref  <= int'(din);
                m_last <= int'(din);
                if (!m_have) begin
                    m_have   <= 1;
                    m_streak <= 0;
                end else if (int'(din) == (m_ref + 1) % (1 << c_width)) begin
                    if (m_locked) begin
                        if (din == 0) begin
                            m_wrapp <= 1;
                            m_wraps <= m_wraps + 1;
                        end
                    end else if (m_streak + 1 == c_lock) begin
                        m_locked <= 1;
                        m_streak <= 0;
                    end else begin
                        m_streak <= m_streak + 1;
                    end
                end else begin
                    if (m_locked) begin
                        m_errp   <= 1;
                        m_errs   <= m_errs + 1;
                        m_locked <= 0;
                    end
                    m_streak <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("locked",      a_locked, m_locked);
        chk("err_pulse",   a_errp,   m_errp);
        chk("wrap_pulse",  a_wrapp,  m_wrapp);
        chk("err_count",   a_errc,   sat(m_errs, 8));
        chk("wrap_count",  a_wrapc,  sat(m_wraps, 8));
        chk("last_val",    a_last,   m_last);
        chk("excl_pulses", a_errp & a_wrapp, 0);
        chk("b_locked",    b_locked, m_locked);
        chk("b_err_pulse", b_errp,   m_errp);
        chk("b_wrap_pulse",b_wrapp,  m_wrapp);
        chk("b_err_count", b_errc,   sat(m_errs, 2));
        chk("b_wrap_count",b_wrapc,  sat(m_wraps, 2));
        chk("b_last_val",  b_last,   m_last);
    end

    task automatic step(input logic v, input logic [3:0] d);
        valid = v;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] v;
        rst_n = 1'b0;
        valid = 1'b0;
        din   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", a_locked, 0);
        chk("rst_errc", a_errc, 0);
        chk("rst_last", a_last, 0);
        rst_n = 1'b1;
        step(0, 4'd0);

        // Lock and count
        step(1, 4'd5); step(1, 4'd6); step(1, 4'd7);
        chk("pre_lock", a_locked, 0);
        step(1, 4'd8);
        chk("lock_locked", a_locked, 1);
        chk("lock_errc", a_errc, 0);
        chk("lock_last", a_last, 8);

        // Wrap
        for (int i = 9; i <= 15; i++) step(1, 4'(i));
        step(1, 4'd0);
        chk("wrap_pulse_hi", a_wrapp, 1);
        chk("wrap_cnt1", a_wrapc, 1);
        step(1, 4'd1);
        chk("wrap_pulse_lo", a_wrapp, 0);
        chk("wrap_locked", a_locked, 1);

        // Error and relock
        for (int i = 2; i <= 9; i++) step(1, 4'(i));
        step(1, 4'd12);
        chk("err_pulse_hi", a_errp, 1);
        chk("err_cnt1", a_errc, 1);
        chk("err_unlocked", a_locked, 0);
        step(1, 4'd13);
        chk("err_pulse_lo", a_errp, 0);
        step(1, 4'd14); step(1, 4'd15);
        chk("relocked", a_locked, 1);

        // Stall and repeat
        step(1, 4'd0); step(1, 4'd1); step(1, 4'd2); step(1, 4'd3);
        for (int i = 0; i < 5; i++) step(0, 4'($urandom_range(0, 15)));
        chk("stall_locked", a_locked, 1);
        chk("stall_last", a_last, 3);
        chk("stall_errc", a_errc, 1);
        step(1, 4'd3);
        chk("repeat_errp", a_errp, 1);
        chk("repeat_errc", a_errc, 2);

        // Saturation on the narrow instance
        v = 4'd3;
        for (int i = 0; i < 5; i++) begin
            step(1, v + 4'd1); step(1, v + 4'd2); step(1, v + 4'd3);
            v = v + 4'd3;
            step(1, v);
            chk("sat_errp", b_errp, 1);
        end
        chk("sat_b_errc", b_errc, 3);
        chk("sat_a_errc", a_errc, 7);

        // Async reset while locked
        step(1, v + 4'd1); step(1, v + 4'd2); step(1, v + 4'd3);
        chk("pre_rst_locked", a_locked, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_locked", a_locked, 0);
        chk("arst_errc", a_errc, 0);
        chk("arst_wrapc", a_wrapc, 0);
        chk("arst_last", a_last, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(1, 4'd0); step(1, 4'd1); step(1, 4'd2); step(1, 4'd3);
        chk("post_rst_locked", a_locked, 1);
        chk("post_rst_last", a_last, 3);
        step(0, 4'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
